// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard logic: address-width default,
// legal load-latency range and the pending-load tracker entry.
package hazard_pkg;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int REG_ADDR_WIDTH_MAX = 8;
  localparam int LOAD_LATENCY_MIN   = 1;
  localparam int LOAD_LATENCY_MAX   = 4;

  // rd is sized for the widest supported register file; narrower files zero-extend
  typedef struct packed {
    logic                          valid;
    logic [REG_ADDR_WIDTH_MAX-1:0] rd;
  } tracker_entry_t;
endpackage

// File: rtl/pending_load_tracker.sv
// Shift register of loads that have left EX but cannot forward yet, plus a
// per-read-port match against every live entry.
module pending_load_tracker
  import hazard_pkg::*;
#(
  parameter int DEPTH          = 1,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          in_valid,
  input  logic [REG_ADDR_WIDTH-1:0]                     in_rd,
  input  logic [NUM_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ_PORTS-1:0]                     hit
);
  tracker_entry_t [DEPTH-1:0] stage_q;

  // Shifts unconditionally: a stall holds ID, not the loads already past EX.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0].valid <= in_valid;
      stage_q[0].rd    <= REG_ADDR_WIDTH_MAX'(in_rd);
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_port
    logic [DEPTH-1:0] match;
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      assign match[i] = stage_q[i].valid &&
                        (stage_q[i].rd == REG_ADDR_WIDTH_MAX'(read_addr[k]));
    end
    assign hit[k] = |match;
  end
endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard detector: stalls ID while any enabled source register
// matches a load in EX or one still inside the load-latency window.
module load_use_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = REG_ADDR_WIDTH_DEF,
  parameter int NUM_READ_PORTS  = 2,
  parameter int LOAD_LATENCY    = 1,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     EX_valid,
  input  logic                                     EX_mem_to_reg,
  input  logic [REG_ADDR_WIDTH-1:0]                EX_destination_register,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] ID_read_register,
  input  logic [NUM_READ_PORTS-1:0]                ID_read_enable,
  input  logic                                     flush,
  output logic                                     stale,
  output logic [STALL_CNT_WIDTH-1:0]               stall_count
);
  if (LOAD_LATENCY < LOAD_LATENCY_MIN || LOAD_LATENCY > LOAD_LATENCY_MAX) begin : g_bad_latency
    $error("load_use_scoreboard: LOAD_LATENCY must be 1..4");
  end
  if (NUM_READ_PORTS < 1) begin : g_bad_ports
    $error("load_use_scoreboard: NUM_READ_PORTS must be >= 1");
  end
  if (REG_ADDR_WIDTH < 1 || REG_ADDR_WIDTH > REG_ADDR_WIDTH_MAX) begin : g_bad_width
    $error("load_use_scoreboard: REG_ADDR_WIDTH out of range");
  end

  localparam int DEPTH = LOAD_LATENCY - 1;

  logic [NUM_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0] read_addr;
  logic [NUM_READ_PORTS-1:0]                     tracker_hit;
  logic [NUM_READ_PORTS-1:0]                     port_hit;
  logic                                          ex_load;

  assign read_addr = ID_read_register;
  // x0 is hardwired zero, so a load to it never produces anything to wait for
  assign ex_load   = EX_valid && EX_mem_to_reg && (EX_destination_register != '0);

  if (DEPTH > 0) begin : g_tracker
    pending_load_tracker #(
      .DEPTH          (DEPTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_READ_PORTS (NUM_READ_PORTS)
    ) u_tracker (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (ex_load),
      .in_rd     (EX_destination_register),
      .read_addr (read_addr),
      .hit       (tracker_hit)
    );
  end else begin : g_no_tracker
    assign tracker_hit = '0;
  end

  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_port
    assign port_hit[k] = ID_read_enable[k] && (read_addr[k] != '0) &&
                         ((ex_load && (read_addr[k] == EX_destination_register)) ||
                          tracker_hit[k]);
  end

  // A flushed ID instruction is discarded, so there is nothing to hold.
  assign stale = reset_n && !flush && (|port_hit);

  always_ff @(posedge clk) begin
    if (!reset_n)                        stall_count <= '0;
    else if (stale && !(&stall_count))   stall_count <= stall_count + STALL_CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Randomized and directed bench: five scoreboards (latency 1..4, plus a
// 3-bit-counter copy at latency 2) share stimulus against a load-history model.
module tb_load_use_scoreboard;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        EX_valid, EX_mem_to_reg, flush;
  logic [4:0]  EX_destination_register;
  logic [9:0]  ID_read_register;
  logic [1:0]  ID_read_enable;
  logic [4:0]  stale_v;
  logic [3:0][31:0] cnt32;
  logic [2:0]  cnt3;

  int vectors = 0;
  int miscompares = 0;
  // hist[j] = rd of the qualifying load that was in EX j+1 cycles ago (0 = none)
  int    hist[4];
  longint cnt_exp[5];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    load_use_scoreboard #(
      .REG_ADDR_WIDTH(5), .NUM_READ_PORTS(2), .LOAD_LATENCY(i+1), .STALL_CNT_WIDTH(32)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .EX_valid(EX_valid), .EX_mem_to_reg(EX_mem_to_reg),
      .EX_destination_register(EX_destination_register), .ID_read_register(ID_read_register),
      .ID_read_enable(ID_read_enable), .flush(flush), .stale(stale_v[i]), .stall_count(cnt32[i])
    );
  end

  load_use_scoreboard #(
    .REG_ADDR_WIDTH(5), .NUM_READ_PORTS(2), .LOAD_LATENCY(2), .STALL_CNT_WIDTH(3)
  ) u_sat (
    .clk(clk), .reset_n(reset_n), .EX_valid(EX_valid), .EX_mem_to_reg(EX_mem_to_reg),
    .EX_destination_register(EX_destination_register), .ID_read_register(ID_read_register),
    .ID_read_enable(ID_read_enable), .flush(flush), .stale(stale_v[4]), .stall_count(cnt3)
  );

  function automatic int lat(int i);
    return (i < 4) ? i + 1 : 2;
  endfunction

  function automatic longint cmax(int i);
    return (i < 4) ? 64'hFFFF_FFFF : 64'd7;
  endfunction

  function automatic longint cnt_act(int i);
    return (i < 4) ? longint'(cnt32[i]) : longint'(cnt3);
  endfunction

  function automatic int cur_load();
    return (EX_valid && EX_mem_to_reg && EX_destination_register != 0) ?
           int'(EX_destination_register) : 0;
  endfunction

  // A read must wait while its register is the target of a load issued
  // fewer than L cycles ago (the current EX load counts as age 0).
  function automatic bit exp_stale(int L);
    int a;
    if (!reset_n || flush) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      a = int'(ID_read_register[k*5 +: 5]);
      if (ID_read_enable[k] && a != 0) begin
        if (a == cur_load()) return 1'b1;
        for (int j = 0; j < L - 1; j++) if (hist[j] == a) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic drive(bit v, bit m, int rd, int r0, bit e0, int r1, bit e1, bit fl);
    EX_valid = v; EX_mem_to_reg = m; EX_destination_register = 5'(rd);
    ID_read_register = {5'(r1), 5'(r0)}; ID_read_enable = {e1, e0}; flush = fl;
    #1;
  endtask

  task automatic tick();
    bit s[5];
    int q;
    for (int i = 0; i < 5; i++) s[i] = exp_stale(lat(i));
    q = cur_load();
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      if (!reset_n) cnt_exp[i] = 0;
      else if (s[i] && cnt_exp[i] < cmax(i)) cnt_exp[i]++;
    end
    if (!reset_n) hist = '{0, 0, 0, 0};
    else begin
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = q;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 1, 5, 5, 1, 5, 1, 0);
    vectors++;
    if (stale_v !== 5'b0) begin
      $display("FAIL reset_stale: got %b want 00000", stale_v); miscompares++;
    end
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (cnt_act(i) !== 0) begin
        $display("FAIL reset_count[%0d]: got %0d want 0", i, cnt_act(i)); miscompares++;
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_l1_basic();
    int n;
    do_reset();
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1, 1, 5, 5, 1, 0, 0, 0);
      else        drive(0, 0, 0, 5, 1, 0, 0, 0);
      n += int'(stale_v[0]);
      tick();
    end
    vectors += 2;
    if (n != 1) begin $display("FAIL l1_stall_len: got %0d want 1", n); miscompares++; end
    if (cnt32[0] !== 32'd1) begin
      $display("FAIL l1_count: got %0d want 1", cnt32[0]); miscompares++;
    end
  endtask

  task automatic test_distance(int d);
    int n[5];
    int want;
    do_reset();
    n = '{0, 0, 0, 0, 0};
    for (int c = 0; c < 8; c++) begin
      drive(c == 0, c == 0, (c == 0) ? 7 : 0, (c >= d - 1) ? 7 : 0, c >= d - 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
        n[i] += int'(stale_v[i]);
        vectors++;
        if (stale_v[i] !== exp_stale(lat(i))) begin
          $display("FAIL dist%0d_stale[%0d] cyc%0d: got %b want %b", d, i, c, stale_v[i],
                   exp_stale(lat(i)));
          miscompares++;
        end
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      want = (lat(i) >= d) ? lat(i) - d + 1 : 0;
      vectors++;
      if (n[i] != want) begin
        $display("FAIL dist%0d_len[%0d]: got %0d want %0d", d, i, n[i], want); miscompares++;
      end
    end
  endtask

  task automatic test_x0_disabled();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      drive(1, 1, 0, 0, 1, 0, 1, 0);
      else if (c == 1) drive(1, 1, 9, 0, 0, 9, 0, 0);
      else             drive(0, 0, 0, 0, 1, 9, 0, 0);
      vectors++;
      if (stale_v !== 5'b0) begin
        $display("FAIL x0_disabled cyc%0d: got %b want 00000", c, stale_v); miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 4, 4, 1, 0, 0, 1);
    vectors++;
    if (stale_v !== 5'b0) begin
      $display("FAIL flush_same_cycle: got %b want 00000", stale_v); miscompares++;
    end
    tick();
    drive(0, 0, 0, 4, 1, 0, 0, 0);
    vectors++;
    if (stale_v !== 5'b11110) begin
      $display("FAIL flush_tracker_kept: got %b want 11110", stale_v); miscompares++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      drive(1, 1, 3, 0, 0, 0, 0, 0);
      else if (c == 1) drive(1, 1, 6, 3, 1, 6, 1, 0);
      else             drive(0, 0, 0, 3, 1, 6, 1, 0);
      n += int'(stale_v[3]);
      tick();
    end
    vectors++;
    if (n != 4) begin $display("FAIL b2b_stall_len: got %0d want 4", n); miscompares++; end
    do_reset();
    drive(1, 1, 3, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 6, 3, 1, 6, 1, 0);
    vectors++;
    if (stale_v[3] !== 1'b1) begin
      $display("FAIL b2b_mid_stall: got %b want 1", stale_v[3]); miscompares++;
    end
    tick();
    reset_n = 1'b0;
    drive(0, 0, 0, 3, 1, 6, 1, 0);
    vectors++;
    if (stale_v !== 5'b0) begin
      $display("FAIL b2b_reset_stale: got %b want 00000", stale_v); miscompares++;
    end
    tick();
    vectors++;
    if (cnt32[3] !== 32'd0) begin
      $display("FAIL b2b_reset_count: got %0d want 0", cnt32[3]); miscompares++;
    end
    reset_n = 1'b1;
    drive(0, 0, 0, 3, 1, 6, 1, 0);
    vectors++;
    if (stale_v !== 5'b0) begin
      $display("FAIL b2b_residual: got %b want 00000", stale_v); miscompares++;
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1, 1, 8, 8, 1, 0, 0, 0);
      tick();
    end
    vectors += 2;
    if (cnt3 !== 3'd7) begin $display("FAIL sat_count: got %0d want 7", cnt3); miscompares++; end
    if (cnt32[1] !== 32'd10) begin
      $display("FAIL sat_wide_count: got %0d want 10", cnt32[1]); miscompares++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0);
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (stale_v[i] !== exp_stale(lat(i))) begin
          $display("FAIL rand_stale[%0d] cyc%0d: got %b want %b", i, c, stale_v[i],
                   exp_stale(lat(i)));
          miscompares++;
        end
      end
      tick();
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (cnt_act(i) !== cnt_exp[i]) begin
          $display("FAIL rand_count[%0d] cyc%0d: got %0d want %0d", i, c, cnt_act(i), cnt_exp[i]);
          miscompares++;
        end
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    hist = '{0, 0, 0, 0};
    cnt_exp = '{0, 0, 0, 0, 0};
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_l1_basic();
    test_distance(1);
    test_distance(3);
    test_distance(4);
    test_x0_disabled();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_use_scoreboard.md
LOAD_USE_SCOREBOARD -- requirements
Module: load_use_scoreboard

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5: register-address width.
REQ-002 Parameter NUM_READ_PORTS, default 2: number of ID-stage source-register ports compared.
REQ-003 Parameter LOAD_LATENCY, default 1, legal 1..4: cycles after EX before load data can be forwarded.
REQ-004 Parameter STALL_CNT_WIDTH, default 32: width of the stall performance counter.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset_n  input  1  synchronous active-low reset.
REQ-008 EX_valid  input  1  EX stage holds a real instruction, not a bubble.
REQ-009 EX_mem_to_reg  input  1  EX instruction is a load.
REQ-010 EX_destination_register  input  REG_ADDR_WIDTH  destination register of the EX instruction.
REQ-011 ID_read_register  input  NUM_READ_PORTS*REG_ADDR_WIDTH  packed ID source registers; port k occupies bits [k*W +: W].
REQ-012 ID_read_enable  input  NUM_READ_PORTS  per-port flag: the ID instruction actually reads that source.
REQ-013 flush  input  1  the ID instruction is being discarded this cycle (taken branch or jump).
REQ-014 stale  output  1  high: hold PC and IF/ID, insert a bubble into EX.
REQ-015 stall_count  output  STALL_CNT_WIDTH  saturating count of cycles with stale high.

Function
REQ-016 An EX load qualifies only when EX_valid=1, EX_mem_to_reg=1 and EX_destination_register!=0.
REQ-017 The pending tracker has LOAD_LATENCY-1 stages, each holding {valid, rd}; with LOAD_LATENCY=1 it has no stages.
REQ-018 Every clock, stage 0 captures the qualifying-EX-load flag and its rd, and stage i captures stage i-1; shifting continues while stale=1.
REQ-019 Port k hits when ID_read_enable[k]=1, its address is nonzero, and it equals the rd of the qualifying EX load or of any valid tracker stage.
REQ-020 stale is combinational: the OR of all port hits, forced to 0 while flush=1 or reset_n=0.
REQ-021 Register x0 never causes a stall, on any port or at any stage.
REQ-022 With LOAD_LATENCY=L, a load followed by a dependent instruction stalls exactly L cycles; at distance d (1 <= d <= L) it stalls L-d+1 cycles; at distance d > L it does not stall.
REQ-023 Several loads in flight to different registers each raise a hit independently; stale stays high until no hit remains.
REQ-024 flush does not clear the tracker, because loads already past EX still complete.
REQ-025 stall_count increments by 1 at each clock edge where stale=1 and holds at 2^STALL_CNT_WIDTH-1.

Reset
REQ-026 When reset_n=0 at a clock edge, every tracker stage becomes valid=0, rd=0, and stall_count becomes 0.
REQ-027 Reset asserted mid-stall drops stale to 0 in the same cycle and discards all pending loads; there is no residual stall after reset is released.

Structure
REQ-028 The shared package hazard_pkg holds the REG_ADDR_WIDTH default, the LOAD_LATENCY legal range, and the {valid, rd} tracker-entry typedef.
REQ-029 The tracker shift register is the sub-module pending_load_tracker (parameters DEPTH, REG_ADDR_WIDTH; one hit-vector output per port); the top module holds the EX compare, the stale logic and the counter.
REQ-030 An elaboration-time check rejects LOAD_LATENCY outside 1..4 and NUM_READ_PORTS < 1.

Verification
REQ-031 L=1: load x5 in EX, ID reads x5 on port 0 -> stale=1 for 1 cycle, then 0; stall_count=1.
REQ-032 L=3: load x7, dependent ID read of x7 at distance 1 -> stale high for 3 consecutive cycles; at distance 3 -> 1 cycle; at distance 4 -> 0 cycles.
REQ-033 Load x0 with an ID read of x0, and load x9 with port 1 read of x9 but ID_read_enable[1]=0 -> stale=0 throughout.
REQ-034 L=2: hit on x4 with flush=1 in the same cycle -> stale=0 that cycle; tracker still holds x4 the next cycle (a read of x4 then stalls).
REQ-035 L=4: back-to-back loads x3 and x6, then ID reads x3 and x6 -> stale stays high until the last tracker entry for x6 retires; reset_n=0 mid-stall -> stale=0 and stall_count=0 immediately.
REQ-036 STALL_CNT_WIDTH=3: hold a hit for 10 cycles -> stall_count reaches 7 and stays at 7.
